// File: rtl/iter_mul_acc_unit.sv
// iter_mul_acc_unit
// Iterative multiply / multiply-accumulate unit that owns the HI/LO pair.
// Retires RADIX_BITS multiplier bits per cycle on operand magnitudes and
// applies the sign and accumulation in a final cycle.
//
// Ports:
//   clk, resetn        clock, async active-low reset
//   flush              cancel the operation in flight (no done, HI/LO kept)
//   start, op, a, b    request, sampled in IDLE only
//   hilo_we/sel/wdata  direct MTHI/MTLO write, honoured in IDLE only
//   busy               high while CALC or FINAL
//   done               one-cycle pulse, hi/lo already updated
//   hi, lo             architectural registers
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; direct HI/LO writes accepted
// S_CALC  | one radix step per cycle, N steps total
// S_FINAL | apply sign, combine with HI/LO, raise done

module iter_mul_acc_unit #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / RADIX_BITS;
  localparam int CW = $clog2(N + 1);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINAL} state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic            sign_q;
  logic [W2-1:0]   mcand_sh;
  logic [WIDTH-1:0] mplier;
  logic [W2-1:0]   partial;
  logic [CW-1:0]   cnt;

  logic             op_valid;
  logic             op_signed;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [W2-1:0]    pp;
  logic [W2-1:0]    p_final;
  logic [W2-1:0]    acc_new;

  always_comb begin
    op_valid  = (op != 3'b000) && (op != 3'b111);
    // MULT, MADD and MSUB are the odd codes
    op_signed = op[0];
    a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
    b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
    // multiplicand is kept pre-shifted, multiplier consumed LSB first
    pp        = mcand_sh * {{(W2-RADIX_BITS){1'b0}}, mplier[RADIX_BITS-1:0]};
    p_final   = sign_q ? -partial : partial;
    case (op_q)
      3'b011, 3'b100: acc_new = {hi, lo} + p_final;
      3'b101, 3'b110: acc_new = {hi, lo} - p_final;
      default:        acc_new = p_final;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      op_q     <= 3'b000;
      sign_q   <= 1'b0;
      mcand_sh <= '0;
      mplier   <= '0;
      partial  <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // HI/LO is only read in FINAL, so a same-edge direct write is
          // naturally seen by the accumulate that starts here
          if (hilo_we) begin
            if (hilo_sel) hi <= hilo_wdata;
            else          lo <= hilo_wdata;
          end
          if (start && op_valid && !flush) begin
            op_q     <= op;
            sign_q   <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            mcand_sh <= {{WIDTH{1'b0}}, a_mag};
            mplier   <= b_mag;
            partial  <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= S_CALC;
          end
        end
        S_CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            partial  <= partial + pp;
            mcand_sh <= mcand_sh << RADIX_BITS;
            mplier   <= mplier >> RADIX_BITS;
            cnt      <= cnt + 1'b1;
            if (cnt == CW'(N - 1)) state <= S_FINAL;
          end
        end
        S_FINAL: begin
          busy  <= 1'b0;
          state <= S_IDLE;
          if (!flush) begin
            {hi, lo} <= acc_new;
            done     <= 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_mul_acc_unit.sv
module tb_iter_mul_acc_unit;

  logic        clk = 1'b0;
  logic        resetn, flush, start, hilo_we, hilo_sel;
  logic [2:0]  op;
  logic [31:0] a, b, hilo_wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        flush8, start8, hilo_we8, hilo_sel8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hilo_wdata8;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] v;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];

  logic done_q  = 1'b0;
  logic done8_q = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iter_mul_acc_unit #(.WIDTH(32), .RADIX_BITS(2)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .start(start), .op(op),
    .a(a), .b(b), .hilo_we(hilo_we), .hilo_sel(hilo_sel),
    .hilo_wdata(hilo_wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  iter_mul_acc_unit #(.WIDTH(8), .RADIX_BITS(4)) dut8 (
    .clk(clk), .resetn(resetn), .flush(flush8), .start(start8), .op(op8),
    .a(a8), .b(b8), .hilo_we(hilo_we8), .hilo_sel(hilo_sel8),
    .hilo_wdata(hilo_wdata8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event seen, required none (cycle %0d)", nm, cyc);
  endtask

  // monitors: pop and compare whenever a done pulse is presented
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (q32.size() == 0) fail_evt("unexpected_done32");
      else begin
        e = q32.pop_front();
        chk("hilo32", {hi, lo}, e.v);
        chk("latency32", 64'(cyc), 64'(e.cyc));
        chk("busy_at_done32", {63'b0, busy}, 64'd0);
      end
      if (done_q) fail_evt("done32_wide");
    end
    done_q = done;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) fail_evt("unexpected_done8");
      else begin
        e = q8.pop_front();
        chk("hilo8", {48'b0, hi8, lo8}, e.v);
        chk("latency8", 64'(cyc), 64'(e.cyc));
      end
      if (done8_q) fail_evt("done8_wide");
    end
    done8_q = done8;
  end

  // all tasks start and end at a negedge
  task automatic issue(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input bit push, input logic [63:0] e);
    exp_t x;
    op = o; a = aa; b = bb; start = 1'b1;
    if (push) begin
      x.v = e; x.cyc = cyc + 18;
      q32.push_back(x);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue8(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                        input logic [15:0] e);
    exp_t x;
    op8 = o; a8 = aa; b8 = bb; start8 = 1'b1;
    x.v = {48'b0, e}; x.cyc = cyc + 4;
    q8.push_back(x);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic drain32();
    for (int i = 0; i < 60 && q32.size() != 0; i++) @(negedge clk);
    if (q32.size() != 0) begin
      fail_evt("timeout32");
      q32.delete();
    end
  endtask

  task automatic drain8();
    for (int i = 0; i < 20 && q8.size() != 0; i++) @(negedge clk);
    if (q8.size() != 0) begin
      fail_evt("timeout8");
      q8.delete();
    end
  endtask

  task automatic wait_done32();
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i == 40) fail_evt("timeout_done32");
  endtask

  function automatic logic [15:0] model8(input logic [2:0] o, input logic [7:0] x,
                                         input logic [7:0] y, input logic [15:0] acc);
    logic [15:0] p;
    if (o[0]) p = 16'($signed({{8{x[7]}}, x}) * $signed({{8{y[7]}}, y}));
    else      p = {8'b0, x} * {8'b0, y};
    case (o)
      3'd3, 3'd4: return acc + p;
      3'd5, 3'd6: return acc - p;
      default:    return p;
    endcase
  endfunction

  initial begin
    logic [15:0] m8;
    logic [2:0]  ro;
    logic [7:0]  ra, rb;
    resetn = 1'b0; flush = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
    hilo_we = 1'b0; hilo_sel = 1'b0; hilo_wdata = '0;
    flush8 = 1'b0; start8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0;
    hilo_we8 = 1'b0; hilo_sel8 = 1'b0; hilo_wdata8 = '0;
    repeat (3) @(negedge clk);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_busy_done", {62'b0, busy, done}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    issue(3'd1, 32'hFFFF_FFFE, 32'd4, 1, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("busy_cycle1", {63'b0, busy}, 64'd1);
    drain32();
    issue(3'd2, 32'hFFFF_FFFE, 32'd4, 1, 64'h0000_0003_FFFF_FFF8);
    drain32();
    issue(3'd4, 32'd2, 32'd3, 1, 64'h0000_0003_FFFF_FFFE);
    drain32();
    issue(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'h0000_0003_FFFF_FFFD);
    drain32();

    // back-to-back: second start presented in the done cycle
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1, 64'h4000_0000_0000_0000);
    wait_done32();
    issue(3'd1, 32'h8000_0000, 32'd1, 1, 64'hFFFF_FFFF_8000_0000);
    drain32();

    resetn = 1'b0;
    @(negedge clk);
    chk("reset2_hilo", {hi, lo}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    issue(3'd5, 32'd1, 32'd1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    drain32();

    // flush in cycle 5, new start in cycle 6
    issue(3'd1, 32'd3, 32'd5, 0, 64'd0);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'b0, busy}, 64'd0);
    chk("flush_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(3'd2, 32'd7, 32'd9, 1, 64'd63);
    drain32();

    // start pulses while busy are ignored
    issue(3'd2, 32'd5, 32'd6, 1, 64'd30);
    @(negedge clk);
    op = 3'd1; a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain32();
    repeat (25) @(negedge clk);
    chk("ignored_start_hilo", {hi, lo}, 64'd30);

    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h1234;
    @(negedge clk);
    hilo_we = 1'b0;
    chk("mthi", {hi, lo}, 64'h0000_1234_0000_001E);
    hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'h55;
    @(negedge clk);
    hilo_we = 1'b0;
    chk("mtlo", {hi, lo}, 64'h0000_1234_0000_0055);

    issue(3'd2, 32'd2, 32'd2, 1, 64'd4);
    @(negedge clk);
    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'hDEAD;
    @(negedge clk);
    hilo_we = 1'b0;
    chk("we_while_busy", {hi, lo}, 64'h0000_1234_0000_0055);
    drain32();

    // direct write lands first, accumulate sees lo=10
    hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'd10;
    issue(3'd4, 32'd2, 32'd3, 1, 64'd16);
    hilo_we = 1'b0;
    drain32();

    op = 3'd0; start = 1'b1;
    @(negedge clk);
    chk("op0_ignored", {63'b0, busy}, 64'd0);
    op = 3'd7;
    @(negedge clk);
    chk("op7_ignored", {63'b0, busy}, 64'd0);
    op = 3'd1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_with_start", {63'b0, busy}, 64'd0);

    // async reset mid-CALC
    issue(3'd1, 32'd3, 32'd3, 0, 64'd0);
    repeat (4) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_hilo", {hi, lo}, 64'd0);
    chk("async_reset_busy", {63'b0, busy}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (25) @(negedge clk);

    // narrow configuration, latency 4
    issue8(3'd1, 8'h80, 8'h80, 16'h4000);
    drain8();
    issue8(3'd2, 8'hFF, 8'hFF, 16'hFE01);
    drain8();
    m8 = 16'hFE01;
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(1, 6));
      ra = 8'($urandom);
      rb = 8'($urandom);
      m8 = model8(ro, ra, rb, m8);
      issue8(ro, ra, rb, m8);
      drain8();
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
